clb_add_sched: RTL
==================

# clb_add_sched

Round-robin scheduler that shares one `clb_add` adder instance among `NREQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and registers the granted pair into an operand stage. It drives the adder from that stage and captures the sum, tagged with the requester index, in a result stage, which is presented to a single downstream consumer under `send_data` backpressure. It sits between the CLB request fabric and the shared adder, replacing direct `rdy`/`send_data` wiring when more than one source needs the adder.

## Interface

- `WIDTH`, 32, operand width; the sum is `WIDTH+1` bits.
- `NREQ`, 4, number of requesters, 2..16.
- `IDW`, `$clog2(NREQ)`, requester index width; derived, not overridden.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  global enable; low freezes all state.
- `req_vld`  in  NREQ  per-requester operand valid.
- `req_rdy`  out  NREQ  per-requester accept; at most one bit high (one-hot or zero).
- `req_din`  in  NREQ*2*WIDTH  requester i occupies bits `[i*2W +: 2W]`; the upper `WIDTH` bits are operand a, the lower `WIDTH` bits are operand b.
- `dout`  out  WIDTH+1  registered sum, a+b; the carry is in the MSB.
- `dout_id`  out  IDW  index of the requester that produced `dout`.
- `dovld`  out  1  result valid.
- `send_data`  in  1  downstream ready; a result transfers when `dovld & send_data & en`.
- `grant_cnt`  out  NREQ*16  present only with `CLB_ADD_SCHED_STATS_EN`.

## Operation

- Pipeline stages:
  - S1: operand register plus `s1_vld`.
  - S2: result register plus `dovld`.
- Pipeline occupancy forms the FSM:
  - EMPTY: both stages invalid.
  - HALF: exactly one stage valid.
  - FULL: both stages valid.
- Stage advance:
  - S2 may load when `!dovld | send_data`.
  - S1 may load when `!s1_vld | (S2 may load)`.
- Arbitration is combinational:
  - When `en` is high and S1 may load, the first requester with `req_vld` high, searching from `ptr` upward modulo `NREQ`, wins.
  - The winner's `req_rdy` is driven high; all other bits are 0.
  - `req_rdy` never depends on the winner's own `req_vld` through a loop. The search uses `req_vld` only.
- Pointer update: on a handshake with winner w, `ptr` becomes `(w+1) mod NREQ`. Otherwise `ptr` holds.
- The sum is computed by an instance of `clb_add` fed from S1. It is zero-extended, never saturated; for example, all-ones plus all-ones gives carry 1 with low bits `2^W-2`.
- `en` low:
  - `req_rdy` is all 0.
  - No register, counter or pointer changes.
  - `dovld`/`dout` hold, and `send_data` is ignored.
- Reset mid-operation drops in-flight operands and results without completing them.

## Timing

- Reset values:
  - `req_rdy`=0, `dout`=0, `dout_id`=0, `dovld`=0.
  - `s1_vld`=0, `ptr`=0, `grant_cnt`=0.
- Latency: handshake in cycle t gives `dovld` high in cycle t+2 when the path is unblocked.
- Throughput: 1 result per cycle with `send_data` held high.
- Backpressure:
  - `dout`/`dout_id` are stable while `dovld & !send_data`.
  - With S2 and S1 both blocked, `req_rdy` is all 0.
- A simultaneous S2 drain and S1 load in the same cycle is legal; the FSM stays FULL.
- Fairness: under continuous requests from all requesters, each requester is granted exactly once per `NREQ` consecutive grants.

## Configuration

- `CLB_ADD_SCHED_STATS_EN` defined:
  - Adds port `grant_cnt`, one 16-bit counter per requester.
  - A counter increments on each handshake of its requester and wraps from 0xFFFF to 0.
  - Counters freeze with `en` low.
- Macro not defined: the port and the counters are absent, and behaviour is otherwise identical.

## Structure

- Package `clb_pkg`:
  - State enum `clb_sched_st_e` {EMPTY, HALF, FULL}.
  - Constant `CLB_GCNT_W`=16.
- Sub-module `clb_rr_arb` (parameters `NREQ`), holding the pointer and the priority search.
  - Inputs: `req`, `en_grant`, `take`.
  - Outputs: `gnt` (one-hot), `gnt_id`.
- Top level:
  - Instantiates `clb_rr_arb` and `clb_add`.
  - Holds the stage registers, the FSM and the optional counters.

## Test plan

- Reset, then one request from requester 2 with a=5, b=7 and `send_data`=1 → `dovld` high 2 cycles after the handshake, `dout`=12, `dout_id`=2, then `dovld` drops.
- Requesters 0..3 all valid continuously with `send_data`=1 → grant order 0,1,2,3,0,… and one result per cycle.
- a=b=0xFFFFFFFF → `dout`=0x1_FFFFFFFE.
- Hold `send_data`=0 with continuous requests → exactly 2 handshakes, then `req_rdy`=0 and `dout` stable. Release `send_data` → results drain in grant order with none lost or duplicated.
- Drop `en` for 3 cycles mid-stream → no handshakes, outputs frozen, and the stream resumes exactly on re-enable. Assert `rst` low mid-stream → all outputs at reset values immediately.
- With `CLB_ADD_SCHED_STATS_EN` defined: after 5 grants to requester 1, `grant_cnt[1]`=5. Preload to 0xFFFF, grant once → 0.

Source files
------------

// File: rtl/clb_add_sched_pkg.sv
// clb_pkg: shared types and constants for the shared-adder scheduler.
package clb_pkg;
  typedef enum logic [1:0] {EMPTY, HALF, FULL} clb_sched_st_e;
  localparam int CLB_GCNT_W = 16;
endpackage

// File: rtl/clb_add.sv
// clb_add: zero-extended adder; the carry lands in the sum MSB.
module clb_add #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);
  assign sum = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/clb_rr_arb.sv
// clb_rr_arb: round-robin search from ptr; ptr moves past each taken winner.
module clb_rr_arb #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en_grant,
  input  logic            take,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] idx;
  logic           found;
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (en_grant && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr <= '0;
    else if (take) ptr <= (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + IDW'(1);
endmodule

// File: rtl/clb_add_sched.sv
// clb_add_sched: round-robin sharing of one clb_add across NREQ requesters.
// Optional per-requester grant counters under CLB_ADD_SCHED_STATS_EN.
module clb_add_sched
  import clb_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NREQ-1:0]         req_vld,
  output logic [NREQ-1:0]         req_rdy,
  input  logic [NREQ*2*WIDTH-1:0] req_din,
  output logic [WIDTH:0]          dout,
  output logic [IDW-1:0]          dout_id,
  output logic                    dovld,
  input  logic                    send_data
`ifdef CLB_ADD_SCHED_STATS_EN
  ,
  output logic [NREQ*CLB_GCNT_W-1:0] grant_cnt
`endif
);
  clb_sched_st_e      st, st_nxt;
  logic [NREQ-1:0]    gnt;
  logic [IDW-1:0]     gnt_id, s1_id;
  logic               s1_vld, s1_ld, s2_ld, hs, drain;
  logic [WIDTH-1:0]   s1_a, s1_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] pair;

  assign pair = req_din[int'(gnt_id)*2*WIDTH +: 2*WIDTH];

  // rst also gates grants so req_rdy reads 0 while reset is asserted
  clb_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req_vld),
    .en_grant (en & s1_ld & rst),
    .take     (hs),
    .gnt      (gnt),
    .gnt_id   (gnt_id)
  );

  clb_add #(.WIDTH(WIDTH)) u_add (
    .a   (s1_a),
    .b   (s1_b),
    .sum (sum)
  );

  always_ff @(posedge clk or negedge rst)
    if (!rst) st <= EMPTY;
    else st <= st_nxt;

  always_comb begin
    st_nxt = (hs && !drain) ? ((st == EMPTY) ? HALF : FULL) :
             (!hs && drain) ? ((st == FULL) ? HALF : EMPTY) : st;
  end

  always_comb begin
    s2_ld   = !dovld || send_data;
    s1_ld   = (st != FULL) || s2_ld;
    req_rdy = gnt;
    hs      = |gnt;
    drain   = en && dovld && send_data;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1_vld <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_id  <= '0;
    end else if (en && s1_ld) begin
      s1_vld <= hs;
      if (hs) begin
        s1_a  <= pair[2*WIDTH-1:WIDTH];
        s1_b  <= pair[WIDTH-1:0];
        s1_id <= gnt_id;
      end
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      dovld   <= 1'b0;
      dout    <= '0;
      dout_id <= '0;
    end else if (en && s2_ld) begin
      dovld <= s1_vld;
      if (s1_vld) begin
        dout    <= sum;
        dout_id <= s1_id;
      end
    end

`ifdef CLB_ADD_SCHED_STATS_EN
  logic [CLB_GCNT_W-1:0] cnt [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_cnt
    always_ff @(posedge clk or negedge rst)
      if (!rst) cnt[i] <= '0;
      else if (gnt[i]) cnt[i] <= cnt[i] + CLB_GCNT_W'(1);
    assign grant_cnt[i*CLB_GCNT_W +: CLB_GCNT_W] = cnt[i];
  end
`endif
endmodule
